// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues a start bit, then shifts a command
// byte plus odd parity out on device-generated clock edges and reports one done/error per byte.
module ps2_tx #(
  parameter int INHIBIT_CYCLES       = 5000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       error_o,
  output logic       rx_inhibit_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int TMAX = (START_TIMEOUT_CYCLES > BIT_TIMEOUT_CYCLES) ?
                        START_TIMEOUT_CYCLES : BIT_TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SEND,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t state, state_nx;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          clk_s, data_s, fall;
  logic [8:0]    shift;
  logic [3:0]    bitcnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmr;
  logic          ack_err;
  logic          done_q, error_q;

  // Control strobes produced by the next-state logic
  logic accept, shift_en, tmr_ld_start, tmr_ld_bit, ack_cap, finish, finish_err;
  logic tmr_run, expire;

  assign clk_s   = clk_sync[1];
  assign data_s  = data_sync[1];
  assign fall    = clk_prev & ~clk_s;
  assign tmr_run = (state == S_SEND) || (state == S_STOP) ||
                   (state == S_ACK)  || (state == S_WAIT_IDLE);
  // The timer value present in a cycle is the number of cycles left until timeout fires
  assign expire  = (tmr <= TW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    shift_en     = 1'b0;
    tmr_ld_start = 1'b0;
    tmr_ld_bit   = 1'b0;
    ack_cap      = 1'b0;
    finish       = 1'b0;
    finish_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_i) begin
          accept   = 1'b1;
          state_nx = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == '0) state_nx = S_REQUEST;
      end
      S_REQUEST: begin
        tmr_ld_start = 1'b1;
        state_nx     = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          shift_en   = 1'b1;
          tmr_ld_bit = 1'b1;
          if (bitcnt == 4'd8) state_nx = S_STOP;
        end else if (expire) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      S_STOP: begin
        if (fall) begin
          tmr_ld_bit = 1'b1;
          state_nx   = S_ACK;
        end else if (expire) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_cap  = 1'b1;
          state_nx = S_WAIT_IDLE;
        end else if (expire) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          finish     = 1'b1;
          finish_err = ack_err;
          state_nx   = S_IDLE;
        end else if (expire) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift   <= '1;
      bitcnt  <= '0;
      inh_cnt <= '0;
      tmr     <= '0;
      ack_err <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= finish;
      error_q <= finish & finish_err;
      if (accept) begin
        shift   <= {~^data_i, data_i};
        bitcnt  <= '0;
        inh_cnt <= IW'(INHIBIT_CYCLES - 1);
      end else if (shift_en) begin
        // Refill with ones so an over-run would only ever release the data line
        shift  <= {1'b1, shift[8:1]};
        bitcnt <= bitcnt + 4'd1;
      end
      if (state == S_INHIBIT && inh_cnt != '0) inh_cnt <= inh_cnt - IW'(1);
      if (tmr_ld_start) begin
        tmr <= TW'(START_TIMEOUT_CYCLES);
      end else if (tmr_ld_bit) begin
        tmr <= TW'(BIT_TIMEOUT_CYCLES);
      end else if (tmr_run && tmr != '0) begin
        tmr <= tmr - TW'(1);
      end
      if (ack_cap) ack_err <= data_s;
    end
  end

  assign ready_o       = (state == S_IDLE) && !rst_i;
  assign rx_inhibit_o  = (state != S_IDLE);
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign ps2_clk_oe_o  = (state == S_INHIBIT) || (state == S_REQUEST);
  assign ps2_data_oe_o = (state == S_REQUEST) || ((state == S_SEND) && !shift[0]);

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a PS/2 device model clocking at a 40-cycle period plus a frame
// monitor that measures inhibit length, start bit, timeout latency and the done/error result.
module tb_ps2_tx;

  localparam int INH = 20;
  localparam int ST  = 400;
  localparam int BT  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid = 1'b0;
  logic       ready, done, error, rx_inh, clk_oe, data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk, ps2_data;

  // Open-drain bus: either side pulling low wins
  assign ps2_clk  = dev_clk & ~clk_oe;
  assign ps2_data = dev_data & ~data_oe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall_cyc = 0;

  int w_inh, w_req, w_rel, w_dcyc;
  bit w_seen, w_err, w_rdy, w_inh_done, w_inh_prev, w_oe_done;

  ps2_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (ST),
    .BIT_TIMEOUT_CYCLES   (BT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .data_i        (data_in),
    .valid_i       (valid),
    .ready_o       (ready),
    .done_o        (done),
    .error_o       (error),
    .rx_inhibit_o  (rx_inh),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .ps2_clk_oe_o  (clk_oe),
    .ps2_data_oe_o (data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Device: waits for the host to release the clock, then produces n_falls clock pulses.
  // The line is sampled just before each fall, so smp[i] is the bit for fall i+1.
  task automatic dev_xfer(input int n_falls, input bit ack, output logic [10:0] smp,
                          output bit ok);
    int b;
    smp = '1;
    ok  = 1'b0;
    b = 0;
    do begin @(negedge clk); b++; end while (!clk_oe && b < 200);
    if (!clk_oe) return;
    b = 0;
    do begin @(negedge clk); b++; end while (clk_oe && b < 200);
    if (clk_oe) return;
    ok = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < n_falls; i++) begin
      if (i == 10 && ack) begin
        dev_data = 1'b0;
        repeat (5) @(negedge clk);
      end
      smp[i] = ps2_data;
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  // Monitor: w_rel counts cycles from the first released-clock cycle to the done cycle.
  task automatic watch_frame();
    int b;
    w_inh = 0; w_req = 0; w_rel = -1; w_dcyc = 0;
    w_seen = 0; w_err = 0; w_rdy = 0; w_inh_done = 1; w_inh_prev = 0; w_oe_done = 1;
    b = 0;
    do begin @(negedge clk); b++; end while (!clk_oe && b < 200);
    while (clk_oe && !data_oe && w_inh < 1000) begin w_inh++; @(negedge clk); end
    while (clk_oe && data_oe && w_req < 1000) begin w_req++; @(negedge clk); end
    w_inh_prev = rx_inh;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        w_seen = 1; w_err = error; w_rdy = ready; w_inh_done = rx_inh;
        w_oe_done = clk_oe | data_oe; w_dcyc = cyc; w_rel = k;
        break;
      end
      w_inh_prev = rx_inh;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
    total++; if ({clk_oe, data_oe} !== 2'b00) begin bad++; $display("FAIL rst_oe got=%b want=00", {clk_oe, data_oe}); end
    total++; if ({done, error, rx_inh} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {done, error, rx_inh}); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", ready); end
  endtask

  task automatic test_send_ed();
    logic [10:0] smp;
    bit ok;
    @(negedge clk);
    data_in = 8'hED; valid = 1'b1;
    fork
      begin @(negedge clk); valid = 1'b0; end
      dev_xfer(11, 1'b1, smp, ok);
      watch_frame();
    join
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ed_dev_release got=%b want=1", ok); end
    total++; if (w_inh !== INH) begin bad++; $display("FAIL ed_inhibit_len got=%0d want=%0d", w_inh, INH); end
    total++; if (w_req !== 1) begin bad++; $display("FAIL ed_start_bit got=%0d want=1", w_req); end
    // 0xED LSB first: 1,0,1,1,0,1,1,1
    total++; if (smp[7:0] !== 8'b1110_1101) begin bad++; $display("FAIL ed_bits got=%b want=11101101", smp[7:0]); end
    total++; if (smp[8] !== 1'b1) begin bad++; $display("FAIL ed_parity got=%b want=1", smp[8]); end
    total++; if (smp[9] !== 1'b1) begin bad++; $display("FAIL ed_stop got=%b want=1", smp[9]); end
    total++; if ({w_seen, w_err, w_rdy} !== 3'b101) begin bad++; $display("FAIL ed_done got=%b want=101", {w_seen, w_err, w_rdy}); end
    // Data released 40 cycles after the ack fall; +2 sync, +1 to the done cycle
    total++; if (w_dcyc - last_fall_cyc !== 43) begin bad++; $display("FAIL ed_done_time got=%0d want=43", w_dcyc - last_fall_cyc); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] smp1, smp2;
    bit ok1, ok2;
    @(negedge clk);
    data_in = 8'h01; valid = 1'b1;
    fork
      begin @(negedge clk); data_in = 8'hFF; end
      dev_xfer(11, 1'b1, smp1, ok1);
      watch_frame();
    join
    total++; if (smp1[7:0] !== 8'h01) begin bad++; $display("FAIL b2b_first_bits got=%h want=01", smp1[7:0]); end
    total++; if (smp1[8] !== 1'b0) begin bad++; $display("FAIL b2b_first_parity got=%b want=0", smp1[8]); end
    total++; if ({w_seen, w_err, w_rdy} !== 3'b101) begin bad++; $display("FAIL b2b_first_done got=%b want=101", {w_seen, w_err, w_rdy}); end
    fork
      begin
        @(negedge clk);
        total++; if ({clk_oe, ready} !== 2'b10) begin bad++; $display("FAIL b2b_second_accept got=%b want=10", {clk_oe, ready}); end
        valid = 1'b0;
      end
      dev_xfer(11, 1'b1, smp2, ok2);
      watch_frame();
    join
    total++; if (w_inh !== INH) begin bad++; $display("FAIL b2b_second_inhibit got=%0d want=%0d", w_inh, INH); end
    total++; if (smp2[7:0] !== 8'hFF) begin bad++; $display("FAIL b2b_second_bits got=%h want=ff", smp2[7:0]); end
    total++; if (smp2[8] !== 1'b1) begin bad++; $display("FAIL b2b_second_parity got=%b want=1", smp2[8]); end
    total++; if ({w_seen, w_err} !== 2'b10) begin bad++; $display("FAIL b2b_second_done got=%b want=10", {w_seen, w_err}); end
  endtask

  task automatic test_start_timeout();
    @(negedge clk);
    data_in = 8'hF3; valid = 1'b1;
    fork
      begin @(negedge clk); valid = 1'b0; end
      watch_frame();
    join
    total++; if ({w_seen, w_err} !== 2'b11) begin bad++; $display("FAIL st_to_done got=%b want=11", {w_seen, w_err}); end
    total++; if (w_rel !== ST) begin bad++; $display("FAIL st_to_latency got=%0d want=%0d", w_rel, ST); end
    total++; if (w_oe_done !== 1'b0) begin bad++; $display("FAIL st_to_oe_done got=%b want=0", w_oe_done); end
    repeat (5) @(negedge clk);
    total++; if ({clk_oe, data_oe, rx_inh, done} !== 4'b0000) begin bad++; $display("FAIL st_to_after got=%b want=0000", {clk_oe, data_oe, rx_inh, done}); end
  endtask

  task automatic test_bit_timeout();
    logic [10:0] smp;
    bit ok;
    @(negedge clk);
    data_in = 8'h3C; valid = 1'b1;
    fork
      begin @(negedge clk); valid = 1'b0; end
      dev_xfer(5, 1'b0, smp, ok);
      watch_frame();
    join
    total++; if ({w_seen, w_err} !== 2'b11) begin bad++; $display("FAIL bit_to_done got=%b want=11", {w_seen, w_err}); end
    // Fall detected 2 cycles after the pin drops; timer holds 200 from the cycle after that
    total++; if (w_dcyc - last_fall_cyc !== BT + 3) begin bad++; $display("FAIL bit_to_latency got=%0d want=%0d", w_dcyc - last_fall_cyc, BT + 3); end
    total++; if ({w_inh_prev, w_inh_done} !== 2'b10) begin bad++; $display("FAIL bit_to_inhibit got=%b want=10", {w_inh_prev, w_inh_done}); end
  endtask

  task automatic test_no_ack();
    logic [10:0] smp;
    bit ok;
    @(negedge clk);
    data_in = 8'hA5; valid = 1'b1;
    fork
      begin @(negedge clk); valid = 1'b0; end
      dev_xfer(11, 1'b0, smp, ok);
      watch_frame();
    join
    total++; if (smp[7:0] !== 8'hA5) begin bad++; $display("FAIL noack_bits got=%h want=a5", smp[7:0]); end
    total++; if (smp[8] !== 1'b1) begin bad++; $display("FAIL noack_parity got=%b want=1", smp[8]); end
    total++; if ({w_seen, w_err} !== 2'b11) begin bad++; $display("FAIL noack_done got=%b want=11", {w_seen, w_err}); end
    // Clock released 20 cycles after the last fall, then 2 sync cycles + 1
    total++; if (w_dcyc - last_fall_cyc !== 23) begin bad++; $display("FAIL noack_done_time got=%0d want=23", w_dcyc - last_fall_cyc); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] smp;
    bit ok;
    int pulses;
    @(negedge clk);
    data_in = 8'h52; valid = 1'b1;
    fork
      begin @(negedge clk); valid = 1'b0; end
      dev_xfer(3, 1'b0, smp, ok);
    join
    // 0x52 bit 3 is 0, so the host is pulling data low while sending it
    total++; if ({clk_oe, data_oe, rx_inh} !== 3'b011) begin bad++; $display("FAIL mid_before got=%b want=011", {clk_oe, data_oe, rx_inh}); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({clk_oe, data_oe, rx_inh, done, ready} !== 5'b00000) begin bad++; $display("FAIL mid_abort got=%b want=00000", {clk_oe, data_oe, rx_inh, done, ready}); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", ready); end
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_start_timeout();
    test_bit_timeout();
    test_no_ack();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
